// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: 32-step restoring division with sign fix-up,
// holding quotient/remainder until the HI/LO write side acknowledges.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_cancel,
    input  logic             div_ack,
    output logic             div_busy,
    output logic             DIV_Complete,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic             signed_op;
    logic             sign_q;
    logic             sign_r;

    // Handshake: a request is taken when div_start is high in IDLE, or in DONE
    // together with div_ack; div_ack retires a result only in DONE; div_cancel
    // overrides both in every state.
    logic accept;
    always_comb begin
        accept = 1'b0;
        if (!div_cancel && div_start) begin
            accept = (state == IDLE) || (state == DONE && div_ack);
        end
    end

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits.
    logic [WIDTH+1:0] shifted;
    logic             fits;
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        fits    = (shifted >= {2'b00, dvs});
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            dvd          <= '0;
            dvs          <= '0;
            rem          <= '0;
            signed_op    <= 1'b0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_busy     <= 1'b0;
            DIV_Complete <= 1'b0;
        end else if (div_cancel) begin
            state        <= IDLE;
            cnt          <= '0;
            div_busy     <= 1'b0;
            DIV_Complete <= 1'b0;
        end else begin
            if (accept) begin
                dvd       <= dividend;
                dvs       <= divisor;
                signed_op <= div_signed;
                sign_q    <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                sign_r    <= div_signed & dividend[WIDTH-1];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= PREP;
                        div_busy <= 1'b1;
                    end
                end
                PREP: begin
                    // Negating 0x80000000 leaves it unchanged, read as unsigned.
                    if (signed_op && dvd[WIDTH-1]) dvd <= -dvd;
                    if (signed_op && dvs[WIDTH-1]) dvs <= -dvs;
                    rem   <= '0;
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    if (fits) begin
                        rem <= shifted[WIDTH:0] - {1'b0, dvs};
                    end else begin
                        rem <= shifted[WIDTH:0];
                    end
                    dvd <= {dvd[WIDTH-2:0], fits};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    quotient     <= sign_q ? -dvd : dvd;
                    remainder    <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    state        <= DONE;
                    div_busy     <= 1'b0;
                    DIV_Complete <= 1'b1;
                end
                DONE: begin
                    if (accept) begin
                        state        <= PREP;
                        div_busy     <= 1'b1;
                        DIV_Complete <= 1'b0;
                    end else if (div_ack) begin
                        state        <= IDLE;
                        DIV_Complete <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    div_busy     <= 1'b0;
                    DIV_Complete <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: hand-computed DIV/DIVU results, latency,
// hold-in-DONE, back-to-back, cancel and asynchronous reset.
module tb_div_sequencer;

    localparam logic [31:0] S_IDLE = 32'd0;
    localparam logic [31:0] S_PREP = 32'd1;
    localparam logic [31:0] S_ITER = 32'd2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_cancel = 1'b0;
    logic        div_ack = 1'b0;
    logic        div_busy;
    logic        DIV_Complete;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    div_sequencer dut (
        .clk(clk), .resetn(resetn), .div_start(div_start), .div_signed(div_signed),
        .dividend(dividend), .divisor(divisor), .div_cancel(div_cancel),
        .div_ack(div_ack), .div_busy(div_busy), .DIV_Complete(DIV_Complete),
        .quotient(quotient), .remainder(remainder), .dbg_state(dbg_state)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // drivers: every task starts and ends just after a falling edge
    task automatic drive_start(input logic s, input logic [31:0] a, input logic [31:0] b);
        div_start  = 1'b1;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        @(negedge clk);
        div_start  = 1'b0;
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
        exp_q.push_back(eq);
        exp_q.push_back(er);
        drive_start(s, a, b);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        int busy_cnt = 0;
        logic [31:0] eq;
        logic [31:0] er;
        if (div_busy) busy_cnt++;
        while (!DIV_Complete && n < 100) begin
            @(negedge clk);
            n++;
            if (div_busy) busy_cnt++;
        end
        check({tag, "_latency"}, 32'(n), 32'd34);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd34);
        check({tag, "_busy_low_done"}, 32'(div_busy), 32'd0);
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
    endtask

    task automatic ack_done(input string tag);
        div_ack = 1'b1;
        @(negedge clk);
        div_ack = 1'b0;
        check({tag, "_complete_after_ack"}, 32'(DIV_Complete), 32'd0);
        check({tag, "_idle_after_ack"}, 32'(dbg_state), S_IDLE);
    endtask

    initial begin
        int rises;
        #2;
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_busy", 32'(div_busy), 32'd0);
        check("reset_complete", 32'(DIV_Complete), 32'd0);
        check("reset_state", 32'(dbg_state), S_IDLE);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        check("divu_busy_after_start", 32'(div_busy), 32'd1);
        wait_done("divu_100_7");
        ack_done("divu_100_7");

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        wait_done("div_m7_2");
        ack_done("div_m7_2");

        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        wait_done("div_7_m2");
        ack_done("div_7_m2");

        issue(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
        wait_done("divu_by_zero");
        ack_done("divu_by_zero");

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        wait_done("div_overflow");

        // result held while the write side stalls
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_complete", 32'(DIV_Complete), 32'd1);
            check("hold_quotient", quotient, 32'h8000_0000);
            check("hold_remainder", remainder, 32'd0);
        end

        // back-to-back: ack and new start in the same cycle
        div_ack = 1'b1;
        issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0);
        div_ack = 1'b0;
        check("b2b_state_prep", 32'(dbg_state), S_PREP);
        check("b2b_complete_low", 32'(DIV_Complete), 32'd0);
        wait_done("b2b_50_5");
        ack_done("b2b_50_5");

        // cancel on the 10th ITER cycle
        drive_start(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        repeat (9) @(negedge clk);
        check("cancel_in_iter", 32'(dbg_state), S_ITER);
        div_cancel = 1'b1;
        @(negedge clk);
        div_cancel = 1'b0;
        check("cancel_state", 32'(dbg_state), S_IDLE);
        check("cancel_busy", 32'(div_busy), 32'd0);
        check("cancel_complete", 32'(DIV_Complete), 32'd0);
        check("cancel_keep_quotient", quotient, 32'd10);
        check("cancel_keep_remainder", remainder, 32'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (DIV_Complete) rises++;
        end
        check("cancel_no_complete", 32'(rises), 32'd0);

        issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
        wait_done("after_cancel_9_3");
        ack_done("after_cancel_9_3");

        // cancel together with start in IDLE drops the start
        div_cancel = 1'b1;
        drive_start(1'b0, 32'd20, 32'd4);
        div_cancel = 1'b0;
        check("cancel_start_state", 32'(dbg_state), S_IDLE);
        check("cancel_start_busy", 32'(div_busy), 32'd0);

        // asynchronous reset in the middle of ITER
        drive_start(1'b0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("areset_quotient", quotient, 32'd0);
        check("areset_remainder", remainder, 32'd0);
        check("areset_busy", 32'(div_busy), 32'd0);
        check("areset_complete", 32'(DIV_Complete), 32'd0);
        check("areset_state", 32'(dbg_state), S_IDLE);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
        wait_done("after_reset_1000_10");
        ack_done("after_reset_1000_10");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
